// File: rtl/kronos_types.sv
// ----------------------------------------------------------------------------
// kronos_types : shared types for the Kronos front end (IF/ID pipe record,
//                fetch FSM states, canonical NOP).   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package kronos_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipeIFID_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } if_state_e;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/kronos_skid_buf.sv
// ----------------------------------------------------------------------------
// kronos_skid_buf : one-entry pipeIFID_t holding buffer with valid/ready and
//                   flush; a push wins over a simultaneous pop.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module kronos_skid_buf
    import kronos_types::*;
(
    input  logic      clk,
    input  logic      rstz,
    input  logic      flush_i,
    input  logic      in_vld_i,
    output logic      in_rdy_o,
    input  pipeIFID_t in_data_i,
    output logic      out_vld_o,
    input  logic      out_rdy_i,
    output pipeIFID_t out_data_o
);

    logic      vld_q;
    pipeIFID_t data_q;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (flush_i) begin
            vld_q  <= 1'b0;
        end else if (in_vld_i) begin
            vld_q  <= 1'b1;
            data_q <= in_data_i;
        end else if (out_rdy_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign in_rdy_o   = ~vld_q;
    assign out_vld_o  = vld_q;
    assign out_data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/kronos_if.sv
// ----------------------------------------------------------------------------
// kronos_if : RV32I instruction fetch stage with branch redirect and discard
//             of wrong-path fetches. Optional skid: KRONOS_IF_SKID_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module kronos_if
    import kronos_types::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0
)(
    input  logic        clk,
    input  logic        rstz,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic        instr_ack,
    input  logic [31:0] instr_data,
    output pipeIFID_t   fetch,
    output logic        fetch_vld,
    input  logic        fetch_rdy,
    input  logic        branch,
    input  logic [31:0] branch_target
);

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic        busy_q;
    pipeIFID_t   fetch_q;
    logic        fetch_vld_q;

    logic        slot_free;
    logic        start;
    logic        req;
    logic        ack;
    logic        land;
    logic        handshake;
    logic        out_load;
    logic [31:0] target;
    pipeIFID_t   fetched;
    pipeIFID_t   out_data;

    assign target    = branch_target & ~32'h3;
    assign fetched   = '{pc: addr_q, ir: instr_data};
    assign handshake = fetch_vld_q & fetch_rdy;

    // addr_q is presented as soon as the request starts, so pc_q runs one word ahead
    assign start = (state_q == FETCH) & ~busy_q & slot_free;
    assign req   = busy_q | start;
    assign ack   = instr_ack & req;
    assign land  = ack & (state_q == FETCH) & ~branch;

`ifdef KRONOS_IF_SKID_EN
    logic      skid_rdy;
    logic      skid_vld;
    logic      skid_push;
    pipeIFID_t skid_data;

    assign slot_free = skid_rdy;
    assign skid_push = land & fetch_vld_q & ~fetch_rdy;
    assign out_load  = (land & ~skid_push) | (handshake & skid_vld & ~branch);
    assign out_data  = land ? fetched : skid_data;

    kronos_skid_buf u_skid (
        .clk        (clk),
        .rstz       (rstz),
        .flush_i    (branch),
        .in_vld_i   (skid_push),
        .in_rdy_o   (skid_rdy),
        .in_data_i  (fetched),
        .out_vld_o  (skid_vld),
        .out_rdy_i  (handshake),
        .out_data_o (skid_data)
    );
`else
    assign slot_free = ~fetch_vld_q | fetch_rdy;
    assign out_load  = land;
    assign out_data  = fetched;
`endif

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q     <= IDLE;
            pc_q        <= BOOT_ADDR + 32'd4;
            addr_q      <= BOOT_ADDR;
            busy_q      <= 1'b0;
            fetch_q     <= '0;
            fetch_vld_q <= 1'b0;
        end else begin
            if (branch) begin
                if (req & ~ack) begin
                    state_q <= DISCARD;
                    busy_q  <= 1'b1;
                    pc_q    <= target;
                end else begin
                    state_q <= FETCH;
                    busy_q  <= 1'b0;
                    addr_q  <= target;
                    pc_q    <= target + 32'd4;
                end
            end else begin
                case (state_q)
                    IDLE: state_q <= FETCH;
                    FETCH, DISCARD: begin
                        if (ack) begin
                            state_q <= FETCH;
                            busy_q  <= 1'b0;
                            addr_q  <= pc_q;
                            pc_q    <= pc_q + 32'd4;
                        end else if (req) begin
                            busy_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            if (branch) begin
                fetch_vld_q <= 1'b0;
            end else if (out_load) begin
                fetch_q     <= out_data;
                fetch_vld_q <= 1'b1;
            end else if (handshake) begin
                fetch_vld_q <= 1'b0;
            end
        end
    end

    assign instr_addr = addr_q;
    assign instr_req  = req;
    assign fetch      = fetch_q;
    assign fetch_vld  = fetch_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_kronos_if.sv
// ----------------------------------------------------------------------------
// tb_kronos_if : directed bench for kronos_if (vector table + corner sequences).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_kronos_if;
    import kronos_types::*;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic        instr_ack;
    logic [31:0] instr_data;
    pipeIFID_t   fetch;
    logic        fetch_vld;
    logic        fetch_rdy = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_target = 32'h0;

    int unsigned waits = 0;
    int unsigned cnt = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ RV_NOP ^ {a[15:0], 16'h0};
    endfunction

    assign instr_ack  = instr_req && (cnt >= waits);
    assign instr_data = mem(instr_addr);

    always @(posedge clk or negedge rstz) begin
        if (!rstz)                       cnt <= 0;
        else if (instr_req && !instr_ack) cnt <= cnt + 1;
        else                             cnt <= 0;
    end

    kronos_if #(.BOOT_ADDR(32'h100)) dut (
        .clk           (clk),
        .rstz          (rstz),
        .instr_addr    (instr_addr),
        .instr_req     (instr_req),
        .instr_ack     (instr_ack),
        .instr_data    (instr_data),
        .fetch         (fetch),
        .fetch_vld     (fetch_vld),
        .fetch_rdy     (fetch_rdy),
        .branch        (branch),
        .branch_target (branch_target)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstz = 1'b0;
        branch = 1'b0;
        @(negedge clk);
        rstz = 1'b1;
    endtask

    typedef struct {
        logic        rstz;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic      done;
        logic [31:0] exp_pc;
        int        xfers;
        int        stall_acks;
        pipeIFID_t snap;

        // rstz rdy br  tgt           req addr          vld pc
        vt[0] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0};
        vt[2] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
        vt[3] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100};
        vt[4] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104};
        vt[5] = '{1'b1, 1'b1, 1'b1, 32'h203, 1'b1, 32'h10C, 1'b1, 32'h108};
        vt[6] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
        vt[7] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rstz          = vt[i].rstz;
            fetch_rdy     = vt[i].rdy;
            branch        = vt[i].br;
            branch_target = vt[i].tgt;
            #1;
            check($sformatf("vec%0d req", i), 64'(instr_req), 64'(vt[i].req));
            check($sformatf("vec%0d addr", i), 64'(instr_addr), 64'(vt[i].addr));
            check($sformatf("vec%0d vld", i), 64'(fetch_vld), 64'(vt[i].vld));
            if (i == 0) check("reset fetch", 64'(fetch), 64'(0));
            if (vt[i].vld) begin
                check($sformatf("vec%0d pc", i), 64'(fetch.pc), 64'(vt[i].pc));
                check($sformatf("vec%0d ir", i), 64'(fetch.ir), 64'(mem(vt[i].pc)));
            end
        end

        // Stall for 3 cycles mid-stream: stream must stay in order and fetch must hold
        do_reset();
        waits = 0;
        exp_pc = 32'h100;
        xfers = 0;
        stall_acks = 0;
        snap = '0;
        for (int c = 0; c < 20; c++) begin
            if (c != 0) @(negedge clk);
            fetch_rdy = !(c >= 6 && c < 9);
            #1;
            if (c == 6) snap = fetch;
            if (c >= 6 && c < 9 && instr_ack) stall_acks++;
            if (c == 7 || c == 8) begin
                check("stall vld", 64'(fetch_vld), 64'(1));
                check("stall fetch stable", 64'(fetch), 64'(snap));
            end
            if (fetch_vld && fetch_rdy) begin
                check("stream pc", 64'(fetch.pc), 64'(exp_pc));
                check("stream ir", 64'(fetch.ir), 64'(mem(exp_pc)));
                exp_pc = exp_pc + 32'd4;
                xfers++;
            end
        end
        check("stream transfers", 64'(xfers), 64'(15));
`ifdef KRONOS_IF_SKID_EN
        check("stall acks", 64'(stall_acks), 64'(1));
`else
        check("stall acks", 64'(stall_acks), 64'(0));
`endif

        // Branch while a 4-wait request is in flight
        do_reset();
        waits = 4;
        fetch_rdy = 1'b1;
        branch = 1'b1;
        branch_target = 32'h40;
        #1;
        check("idle req", 64'(instr_req), 64'(0));
        @(negedge clk);
        branch = 1'b0;
        #1;
        check("req 0x40", 64'(instr_req), 64'(1));
        check("addr 0x40", 64'(instr_addr), 64'(32'h40));
        @(negedge clk);
        branch = 1'b1;
        branch_target = 32'h203;
        #1;
        check("no ack at branch", 64'(instr_ack), 64'(0));
        @(negedge clk);
        branch = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            #1;
            check("discard req", 64'(instr_req), 64'(1));
            check("discard addr", 64'(instr_addr), 64'(32'h40));
            check("discard vld", 64'(fetch_vld), 64'(0));
            if (instr_ack) done = 1'b1;
            @(negedge clk);
        end
        check("discard ack seen", 64'(done), 64'(1));
        #1;
        check("post-discard req", 64'(instr_req), 64'(1));
        check("post-discard addr", 64'(instr_addr), 64'(32'h200));
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            #1;
            if (fetch_vld) begin
                done = 1'b1;
                check("first valid pc", 64'(fetch.pc), 64'(32'h200));
                check("first valid ir", 64'(fetch.ir), 64'(mem(32'h200)));
            end
        end
        check("branch fetch seen", 64'(done), 64'(1));

        // PC wrap
        do_reset();
        waits = 0;
        fetch_rdy = 1'b1;
        branch = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        @(negedge clk);
        branch = 1'b0;
        #1;
        check("wrap addr0", 64'(instr_addr), 64'(32'hFFFF_FFFC));
        check("wrap req", 64'(instr_req), 64'(1));
        @(negedge clk);
        #1;
        check("wrap addr1", 64'(instr_addr), 64'(32'h0));
        check("wrap pc0", 64'(fetch.pc), 64'(32'hFFFF_FFFC));
        @(negedge clk);
        #1;
        check("wrap pc1", 64'(fetch.pc), 64'(32'h0));
        check("wrap addr2", 64'(instr_addr), 64'(32'h4));

        // Reset while a request is outstanding
        do_reset();
        waits = 4;
        fetch_rdy = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            #1;
            if (fetch_vld) done = 1'b1;
        end
        check("pre-reset vld seen", 64'(done), 64'(1));
        check("pre-reset req", 64'(instr_req), 64'(1));
        rstz = 1'b0;
        #1;
        check("rst req", 64'(instr_req), 64'(0));
        check("rst vld", 64'(fetch_vld), 64'(0));
        check("rst addr", 64'(instr_addr), 64'(32'h100));
        @(negedge clk);
        rstz = 1'b1;
        #1;
        check("restart idle req", 64'(instr_req), 64'(0));
        @(negedge clk);
        #1;
        check("restart req", 64'(instr_req), 64'(1));
        check("restart addr", 64'(instr_addr), 64'(32'h100));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
